// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code receiver and its event FIFO.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    // Event entry layout: {ext, brk, code[7:0]}
    localparam int unsigned ENTRY_W = 10;
    localparam int unsigned EXT     = 9;
    localparam int unsigned BRK     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with registered head, count, full and empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd_c;
    logic             do_wr_c;
    logic [CW-1:0]    count_n_c;

    // A pop frees a slot, so a write is accepted when full if a pop happens alongside it.
    always_comb begin
        do_rd_c   = rd_en & ~empty;
        do_wr_c   = wr_en & (~full | do_rd_c);
        count_n_c = count + CW'(do_wr_c) - CW'(do_rd_c);
    end

    always_ff @(posedge Clk) begin
        if (do_wr_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // rdata is the next head, so it is valid the cycle empty drops and holds when drained.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            rdata  <= '0;
        end else begin
            if (do_wr_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_n_c;
            empty <= (count_n_c == '0);
            full  <= (count_n_c == CW'(DEPTH));
            if (do_rd_c) begin
                if (count > CW'(1)) begin
                    rdata <= mem[rd_ptr + AW'(1)];
                end else if (do_wr_c) begin
                    rdata <= wdata;
                end
            end else if (empty && do_wr_c) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver: synchronises and deframes key frames, folds E0/F0 prefixes
// into tagged key events and buffers them in a FIFO popped by the CPU.
module ps2_scan_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned ERR_W          = 8,
    localparam int unsigned CW            = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               key_clk,
    input  logic               key_data,
    input  logic               rd_en,
    input  logic               ovf_clr,
    output logic [ENTRY_W-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic [CW-1:0]      count,
    output logic               overflow,
    output logic [ERR_W-1:0]   frame_err_cnt,
    output logic [7:0]         last_make
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s_c;
    logic                   data_s_c;
    logic                   fall_c;

    ps2_state_t       state, state_n;
    logic [2:0]       bitcnt, bitcnt_n;
    logic [7:0]       shreg, shreg_n;
    logic             par, par_n;
    logic [TW-1:0]    tmo, tmo_n;
    logic             ext, ext_n;
    logic             brk, brk_n;
    logic [ERR_W-1:0] err_n;
    logic [7:0]       last_n;
    logic             push_c;
    logic             drop_c;
    logic [ENTRY_W-1:0] ev_c;

    // Sync chains reset high so the idle bus does not look like a falling edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], key_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], key_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        clk_s_c  = clk_sync[SYNC_STAGES-1];
        data_s_c = data_sync[SYNC_STAGES-1];
        fall_c   = clk_prev & ~clk_s_c;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= IDLE;
            bitcnt        <= '0;
            shreg         <= '0;
            par           <= 1'b0;
            tmo           <= '0;
            ext           <= 1'b0;
            brk           <= 1'b0;
            frame_err_cnt <= '0;
            last_make     <= '0;
        end else begin
            state         <= state_n;
            bitcnt        <= bitcnt_n;
            shreg         <= shreg_n;
            par           <= par_n;
            tmo           <= tmo_n;
            ext           <= ext_n;
            brk           <= brk_n;
            frame_err_cnt <= err_n;
            last_make     <= last_n;
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_n    = par;
        tmo_n    = '0;
        ext_n    = ext;
        brk_n    = brk;
        err_n    = frame_err_cnt;
        last_n   = last_make;
        push_c   = 1'b0;

        if (state != IDLE && !fall_c) begin
            tmo_n = tmo + TW'(1);
        end

        // Abandoned partial frame: count it, but keep any pending prefix.
        if (state != IDLE && !fall_c && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            tmo_n   = '0;
            if (frame_err_cnt != '1) begin
                err_n = frame_err_cnt + ERR_W'(1);
            end
        end else if (fall_c) begin
            case (state)
                IDLE: begin
                    if (!data_s_c) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n[bitcnt] = data_s_c;
                    bitcnt_n        = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    par_n   = data_s_c;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (data_s_c && (^{shreg, par})) begin
                        if (shreg == PS2_EXT) begin
                            ext_n = 1'b1;
                        end else if (shreg == PS2_BREAK) begin
                            brk_n = 1'b1;
                        end else begin
                            push_c = 1'b1;
                            if (!brk) begin
                                last_n = shreg;
                            end
                            ext_n = 1'b0;
                            brk_n = 1'b0;
                        end
                    end else begin
                        if (frame_err_cnt != '1) begin
                            err_n = frame_err_cnt + ERR_W'(1);
                        end
                        ext_n = 1'b0;
                        brk_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        ev_c      = '0;
        ev_c[EXT] = ext;
        ev_c[BRK] = brk;
        ev_c[7:0] = shreg;
        // Full implies non-empty, so rd_en alone means a pop makes room this cycle.
        drop_c    = push_c & full & ~rd_en;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .wr_en (push_c),
        .wdata (ev_c),
        .rd_en (rd_en),
        .rdata (dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Scoreboard bench for ps2_scan_fifo: drives PS/2 frames and checks popped key events.
module tb_ps2_scan_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 1000;
    localparam int unsigned EW    = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned HALF  = 8;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          key_clk;
    logic          key_data;
    logic          rd_en;
    logic          ovf_clr;
    logic [9:0]    dout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic [EW-1:0] frame_err_cnt;
    logic [7:0]    last_make;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] exp_q[$];
    logic       m_ext;
    logic       m_brk;
    logic       m_ovf;
    logic [7:0] m_last;
    int         m_err;

    always #5 Clk = ~Clk;

    ps2_scan_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TMO),
        .ERR_W          (EW)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .key_clk       (key_clk),
        .key_data      (key_data),
        .rd_en         (rd_en),
        .ovf_clr       (ovf_clr),
        .dout          (dout),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overflow      (overflow),
        .frame_err_cnt (frame_err_cnt),
        .last_make     (last_make)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic ps2_bit(input logic b);
        key_data = b;
        tick(HALF);
        key_clk = 1'b0;
        tick(HALF);
        key_clk = 1'b1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_ovf  = 1'b0;
        m_last = 8'h00;
        m_err  = 0;
    endtask

    // Sends one frame; with pop_at_push, rd_en is pulsed in the cycle the stop edge is processed.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                              input logic pop_at_push);
        logic        p;
        logic [9:0]  bits;
        logic        good;
        p    = ~(^b) ^ par_flip;
        bits = {p, b, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        key_data = stop;
        tick(HALF);
        key_clk = 1'b0;
        if (pop_at_push) begin
            tick(2);
            if (exp_q.size() > 0) check("pushpop_head", 32'(dout), 32'(exp_q.pop_front()));
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
            tick(HALF - 3);
        end else begin
            tick(HALF);
        end
        key_clk = 1'b1;
        good = stop && (^{b, p});
        if (!good) begin
            if (m_err < 255) m_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
            else m_ovf = 1'b1;
            if (!m_brk) m_last = b;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        tick(4);
    endtask

    task automatic good_frame(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic pop_check(input string tag);
        int w;
        w = 0;
        while (empty && w < 50) begin
            tick(1);
            w++;
        end
        if (empty) begin
            check({tag, "_wait"}, 32'(empty), 32'd0);
        end else begin
            if (exp_q.size() > 0) check(tag, 32'(dout), 32'(exp_q.pop_front()));
            else check({tag, "_unexpected"}, 32'(empty), 32'd1);
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
        check({tag, "_err"}, 32'(frame_err_cnt), 32'(m_err));
        check({tag, "_last"}, 32'(last_make), 32'(m_last));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_dout"}, 32'(dout), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_err"}, 32'(frame_err_cnt), 32'd0);
        check({tag, "_last"}, 32'(last_make), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst      = 1'b1;
        key_clk  = 1'b1;
        key_data = 1'b1;
        rd_en    = 1'b0;
        ovf_clr  = 1'b0;
        model_reset();
        tick(4);
        Rst = 1'b0;
        tick(2);
        check_reset_vals("reset");

        // Plain make code
        good_frame(8'h1C);
        check("make_empty", 32'(empty), 32'd0);
        check("make_dout", 32'(dout), 32'h01C);
        check("make_last", 32'(last_make), 32'h1C);
        check("make_count", 32'(count), 32'd1);
        pop_check("make_pop");
        tick(1);
        check("make_empty_after", 32'(empty), 32'd1);

        // Break and extended prefixes fold into tags
        good_frame(8'hF0); good_frame(8'h1C);
        good_frame(8'hE0); good_frame(8'h75);
        good_frame(8'hE0); good_frame(8'hF0); good_frame(8'h75);
        check_status("prefix");
        check("prefix_last_lit", 32'(last_make), 32'h75);
        pop_check("prefix_pop0");
        pop_check("prefix_pop1");
        pop_check("prefix_pop2");
        tick(1);
        check("prefix_drained", 32'(empty), 32'd1);

        // Bad frames clear a pending break prefix
        good_frame(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("bad_err", 32'(frame_err_cnt), 32'd2);
        check_status("bad");
        good_frame(8'h1C);
        pop_check("bad_next_pop");

        // Overflow, then push+pop while full
        for (int i = 1; i <= 9; i++) good_frame(8'(i));
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check_status("ovf");
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        m_ovf   = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        send_frame(8'h0A, 1'b0, 1'b1, 1'b1);
        check("pushpop_count", 32'(count), 32'd8);
        check("pushpop_full", 32'(full), 32'd1);
        check_status("pushpop");
        for (int i = 0; i < 8; i++) pop_check("ovf_pop");
        tick(1);
        check("ovf_drained", 32'(empty), 32'd1);

        // Timeout abandons a partial frame
        for (int i = 0; i < 4; i++) ps2_bit(1'(i == 2));
        tick(TMO + 10);
        m_err++;
        check_status("timeout");
        good_frame(8'h2A);
        pop_check("timeout_next_pop");

        // Reset mid-frame
        good_frame(8'h1C);
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        Rst = 1'b1;
        tick(2);
        Rst = 1'b0;
        model_reset();
        tick(1);
        check_reset_vals("midreset");
        good_frame(8'h2A);
        check_status("postreset");
        pop_check("postreset_pop");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan_fifo.md
Name: ps2_scan_fifo

Overview:
- PS/2 keyboard receiver that replaces the single-byte keycode register feeding the CPU load mux.
- Synchronises key_clk and key_data into the Clk domain and deframes 11-bit PS/2 frames (start, 8 data bits LSB-first, odd parity, stop).
- Folds E0 (extended) and F0 (break) prefixes into tagged key events and buffers those events in a parametrised FIFO.
- The CPU FSM pops events one per instruction, and frame errors, timeouts and overflow are reported.

Parameters:
- FIFO_DEPTH, 8: number of buffered key events; must be a power of two, minimum 2.
- SYNC_STAGES, 2: flop stages on key_clk and key_data; minimum 2.
- TIMEOUT_CYCLES, 50000: Clk cycles without a key_clk falling edge before a partial frame is abandoned.
- ERR_W, 8: width of the frame-error counter.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous active-high reset.
- key_clk  in  1  raw PS/2 clock, asynchronous.
- key_data  in  1  raw PS/2 data, asynchronous.
- rd_en  in  1  pop request for the head entry.
- ovf_clr  in  1  clears the sticky overflow flag.
- dout  out  10  head entry {ext, brk, code[7:0]}, first-word fall-through.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  out  1  sticky flag: a key event was dropped.
- frame_err_cnt  out  ERR_W  saturating count of bad frames.
- last_make  out  8  code of the most recent non-break event, held for legacy readers.

Behaviour:
- Interface: one clock, Clk. Reset Rst is synchronous and active-high.
- Reset values: empty=1, full=0, count=0, dout=0, overflow=0, frame_err_cnt=0, last_make=0. The deframer goes to IDLE and the prefix flags are cleared.
- Rst asserted mid-frame discards the partial frame. The first falling edge after reset is treated as a fresh start bit.
- Synchronisation: key_clk and key_data each pass through SYNC_STAGES flops.
- Edge detect: a falling edge is registered when the previous synced key_clk is 1 and the current synced key_clk is 0. Synced key_data is sampled in that same cycle.
- Deframer states:
  - IDLE: on an edge with data=0 go to DATA and clear bitcnt. An edge with data=1 is ignored.
  - DATA: shift data into bit[bitcnt], increment bitcnt. After bit 7 go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: the frame is good when data=1 and the XOR of the 8 data bits and the parity bit equals 1. Either outcome returns to IDLE.
- Bad frame: frame_err_cnt increments, saturating at all-ones. The byte is discarded and both prefix flags are cleared.
- Timeout: a counter resets on every falling edge and runs in every state other than IDLE. When it reaches TIMEOUT_CYCLES the deframer returns to IDLE, frame_err_cnt increments and the prefix flags are kept.
- Event decode on a good byte:
  - 0xE0: set ext, no push.
  - 0xF0: set brk, no push.
  - Any other byte: push {ext, brk, byte}, then clear ext and brk.
  - If brk=0 for the pushed byte, also load last_make.
- Latency: the push is registered on the Clk edge that processes the stop-bit edge. empty, count and dout reflect the new entry on the following cycle.
- FIFO reads:
  - dout always shows the head entry while empty=0. It holds its last value when empty.
  - Pop occurs when rd_en=1 and empty=0. rd_en while empty is ignored and has no error.
- Simultaneous push and pop: both occur and count is unchanged. This holds when full, and when empty only the push takes effect.
- Full without a pop: the event is dropped and overflow is set.
  - overflow stays set until ovf_clr=1.
  - If ovf_clr and a new drop land in the same cycle, set wins.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. full and empty are derived from count.

Decomposition:
- Package ps2_pkg:
  - constants PS2_EXT=8'hE0 and PS2_BREAK=8'hF0;
  - deframer state encoding IDLE/DATA/PARITY/STOP;
  - entry width constant 10 and field offsets EXT=9, BRK=8.
- Sub-module sync_fifo: parametrised width and depth, first-word fall-through, with count, full and empty outputs. ps2_scan_fifo instantiates it with width 10.

Test Plan:
- Make code: frame 0x1C with correct parity -> after the stop edge, empty=0, dout=0x01C, last_make=0x1C, count=1. Then rd_en for 1 cycle -> empty=1.
- Break and extended events: frames F0,1C, then E0,75, then E0,F0,75 -> entries popped in order 0x11C, 0x275, 0x375. last_make=0x75 and no prefix byte is ever pushed.
- Bad frames: a frame with the parity bit inverted, then a frame with stop=0 -> frame_err_cnt=2, count=0. The next good frame 0x1C -> dout=0x01C with ext=0 and brk=0.
- Overflow: 9 make frames 0x01..0x09 with FIFO_DEPTH=8 and no reads -> full=1, overflow=1. Pops return 0x001..0x008 and 0x09 is lost. ovf_clr -> overflow=0.
- Full-boundary push+pop: FIFO full, rd_en held during a 10th frame's stop edge -> count stays 8 and the new entry is at the tail.
- Timeout and reset: stop key_clk after 4 bits for TIMEOUT_CYCLES+1 cycles -> frame_err_cnt=1, then a clean frame 0x2A decodes correctly. Assert Rst mid-frame -> all outputs return to reset values and the next frame 0x2A decodes correctly.
